// File: rtl/reg_write_back.sv
// reg_write_back
// Write-back end of the multicycle CPU register file. Holds the 32x32
// register array, two registered read ports and a one-deep staged write
// port that commits on the edge after the request is accepted.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   rs_addr, rt_addr       read port addresses (from the read muxes)
//   rd_field               instruction rd field, a destination candidate
//   RegDst                 destination select: rt / rd / $31 / $0 (discard)
//   MemtoReg               data select: alu_out / mdr / pc_plus4 / zero
//   RegWrite               write request, sampled every rising edge
//   alu_out, mdr, pc_plus4 write-data sources
//   read_data1/2           registered contents of rs_addr / rt_addr
//   wb_busy                high while a staged write awaits commit
//   wb_done                one-cycle pulse in the cycle after a commit
//   wb_dst                 destination of the most recent commit
module reg_write_back #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_field,
  input  logic [1:0]        RegDst,
  input  logic [1:0]        MemtoReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mdr,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              wb_busy,
  output logic              wb_done,
  output logic [ADDR_W-1:0] wb_dst
);

  localparam int NREGS = 2 ** ADDR_W;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] regs [NREGS];

  logic [ADDR_W-1:0] dst_sel;
  logic [DATA_W-1:0] data_sel;
  logic              bypass1;
  logic              bypass2;
  logic              committing;

  assign committing = (state == COMMIT);
  assign wb_busy    = committing;

  // Destination and data selection for the write being accepted this edge.
  // RegDst=3 targets $0, so the commit happens but the array is untouched.
  always_comb begin
    dst_sel = '0;
    case (RegDst)
      2'd0:    dst_sel = rt_addr;
      2'd1:    dst_sel = rd_field;
      2'd2:    dst_sel = ADDR_W'(31);
      default: dst_sel = '0;
    endcase

    data_sel = '0;
    case (MemtoReg)
      2'd0:    data_sel = alu_out;
      2'd1:    data_sel = mdr;
      2'd2:    data_sel = pc_plus4;
      default: data_sel = '0;
    endcase
  end

  // A read of the register being committed on this same edge must see the
  // new value, since the array itself only updates at this edge.
  assign bypass1 = committing && (dst_q == rs_addr) && (rs_addr != '0);
  assign bypass2 = committing && (dst_q == rt_addr) && (rt_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dst_q      <= '0;
      data_q     <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      wb_done    <= 1'b0;
      wb_dst     <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wb_done <= committing;

      // $0 is never written, so regs[0] stays at its reset value of zero.
      if (committing) begin
        if (dst_q != '0) begin
          regs[dst_q] <= data_q;
        end
        wb_dst <= dst_q;
      end

      if (rs_addr == '0) begin
        read_data1 <= '0;
      end else if (bypass1) begin
        read_data1 <= data_q;
      end else begin
        read_data1 <= regs[rs_addr];
      end

      if (rt_addr == '0) begin
        read_data2 <= '0;
      end else if (bypass2) begin
        read_data2 <= data_q;
      end else begin
        read_data2 <= regs[rt_addr];
      end

      // A request in either state (re)loads the stage, which gives one
      // commit per cycle while RegWrite stays high.
      case (state)
        IDLE: begin
          if (RegWrite) begin
            dst_q  <= dst_sel;
            data_q <= data_sel;
            state  <= COMMIT;
          end
        end
        default: begin
          if (RegWrite) begin
            dst_q  <= dst_sel;
            data_q <= data_sel;
            state  <= COMMIT;
          end else begin
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_back.sv
module tb_reg_write_back;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_field;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic        RegWrite;
  logic [31:0] alu_out;
  logic [31:0] mdr;
  logic [31:0] pc_plus4;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        wb_busy;
  logic        wb_done;
  logic [4:0]  wb_dst;

  int checks;
  int fails;
  int doneCount;

  // Reference model: architectural register contents plus the one write
  // that has been accepted but not yet committed.
  logic [31:0] mregs [32];
  logic        pendValid;
  logic [4:0]  pendDst;
  logic [31:0] pendData;
  logic [31:0] expRd1;
  logic [31:0] expRd2;
  logic        expDone;
  logic [4:0]  expDst;

  reg_write_back #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_field   (rd_field),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .alu_out    (alu_out),
    .mdr        (mdr),
    .pc_plus4   (pc_plus4),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .wb_busy    (wb_busy),
    .wb_done    (wb_done),
    .wb_dst     (wb_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic modelEdge();
    logic [4:0]  newDst;
    logic [31:0] newData;
    if (reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      pendValid = 1'b0;
      pendDst   = 5'd0;
      pendData  = 32'h0;
      expRd1    = 32'h0;
      expRd2    = 32'h0;
      expDone   = 1'b0;
      expDst    = 5'd0;
    end else begin
      expRd1 = (rs_addr == 5'd0) ? 32'h0 :
               (pendValid && pendDst == rs_addr) ? pendData : mregs[rs_addr];
      expRd2 = (rt_addr == 5'd0) ? 32'h0 :
               (pendValid && pendDst == rt_addr) ? pendData : mregs[rt_addr];
      expDone = pendValid;
      if (pendValid) begin
        if (pendDst != 5'd0) mregs[pendDst] = pendData;
        expDst = pendDst;
      end
      case (RegDst)
        2'd0:    newDst = rt_addr;
        2'd1:    newDst = rd_field;
        2'd2:    newDst = 5'd31;
        default: newDst = 5'd0;
      endcase
      case (MemtoReg)
        2'd0:    newData = alu_out;
        2'd1:    newData = mdr;
        2'd2:    newData = pc_plus4;
        default: newData = 32'h0;
      endcase
      pendValid = RegWrite;
      if (RegWrite) begin
        pendDst  = newDst;
        pendData = newData;
      end
    end
  endtask

  // Drive one cycle of inputs, take the edge, then compare every output
  // against the model one time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic we, input logic [1:0] dsel,
                               input logic [1:0] msel, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] md,
                               input logic [31:0] pc);
    reset    = rst;
    RegWrite = we;
    RegDst   = dsel;
    MemtoReg = msel;
    rs_addr  = rs;
    rt_addr  = rt;
    rd_field = rd;
    alu_out  = alu;
    mdr      = md;
    pc_plus4 = pc;
    @(posedge clk);
    #1;
    modelEdge();
    checkOutput("read_data1", read_data1, expRd1);
    checkOutput("read_data2", read_data2, expRd2);
    checkOutput("wb_busy", {31'b0, wb_busy}, {31'b0, pendValid});
    checkOutput("wb_done", {31'b0, wb_done}, {31'b0, expDone});
    checkOutput("wb_dst", {27'b0, wb_dst}, {27'b0, expDst});
    if (wb_done) doneCount++;
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, rs, rt, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    checks = 0;
    fails = 0;
    doneCount = 0;
    pendValid = 1'b0;
    pendDst = 5'd0;
    pendData = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("reset_busy", {31'b0, wb_busy}, 32'h0);
    checkOutput("reset_done", {31'b0, wb_done}, 32'h0);

    // Preload $5 and $31, then reset clears them
    applyStimulus(1'b0, 1'b1, 2'd0, 2'd0, 5'd0, 5'd5, 5'd0, 32'h0000_0055, 32'h0, 32'h0);
    idle(5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 2'd2, 2'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0031, 32'h0, 32'h0);
    idle(5'd0, 5'd0);
    idle(5'd5, 5'd31);
    checkOutput("preload_r5", read_data1, 32'h0000_0055);
    checkOutput("preload_r31", read_data2, 32'h0000_0031);
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 5'd5, 5'd31, 5'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("reset_rd1", read_data1, 32'h0);
    checkOutput("reset_rd2", read_data2, 32'h0);
    idle(5'd5, 5'd31);
    checkOutput("cleared_r5", read_data1, 32'h0);
    checkOutput("cleared_r31", read_data2, 32'h0);

    // rd destination with mdr data
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd1, 5'd0, 5'd0, 5'd8, 32'h0, 32'hDEAD_BEEF, 32'h0);
    checkOutput("mdr_busy", {31'b0, wb_busy}, 32'h1);
    idle(5'd0, 5'd0);
    checkOutput("mdr_busy_off", {31'b0, wb_busy}, 32'h0);
    checkOutput("mdr_done", {31'b0, wb_done}, 32'h1);
    checkOutput("mdr_dst", {27'b0, wb_dst}, 32'd8);
    idle(5'd8, 5'd0);
    checkOutput("mdr_done_off", {31'b0, wb_done}, 32'h0);
    checkOutput("mdr_r8", read_data1, 32'hDEAD_BEEF);

    // Link write to $31 from pc_plus4
    applyStimulus(1'b0, 1'b1, 2'd2, 2'd2, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0040_0010);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd31);
    checkOutput("link_r31", read_data2, 32'h0040_0010);

    // Write aimed at $0 is dropped but still reported
    applyStimulus(1'b0, 1'b1, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'h1234_5678, 32'h0, 32'h0);
    idle(5'd0, 5'd0);
    checkOutput("zero_done", {31'b0, wb_done}, 32'h1);
    checkOutput("zero_dst", {27'b0, wb_dst}, 32'd0);
    checkOutput("zero_rd1", read_data1, 32'h0);
    checkOutput("zero_rd2", read_data2, 32'h0);
    idle(5'd0, 5'd0);
    checkOutput("zero_read", read_data2, 32'h0);

    // Same-edge bypass on both ports
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd0, 5'd0, 5'd0, 5'd9, 32'hA5A5_A5A5, 32'h0, 32'h0);
    idle(5'd9, 5'd9);
    checkOutput("bypass_rd1", read_data1, 32'hA5A5_A5A5);
    checkOutput("bypass_rd2", read_data2, 32'hA5A5_A5A5);

    // Back-to-back writes
    doneCount = 0;
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd0, 5'd0, 5'd0, 5'd1, 32'h11, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd0, 5'd0, 5'd0, 5'd2, 32'h22, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd0, 5'd0, 5'd0, 5'd3, 32'h33, 32'h0, 32'h0);
    idle(5'd0, 5'd0);
    idle(5'd1, 5'd2);
    checkOutput("b2b_done_count", 32'(doneCount), 32'd3);
    checkOutput("b2b_r1", read_data1, 32'h11);
    checkOutput("b2b_r2", read_data2, 32'h22);
    idle(5'd3, 5'd0);
    checkOutput("b2b_r3", read_data1, 32'h33);

    // Reset on the edge that would commit $3
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd0, 5'd0, 5'd0, 5'd1, 32'h11, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd0, 5'd0, 5'd0, 5'd2, 32'h22, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd0, 5'd0, 5'd0, 5'd3, 32'h33, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 2'd1, 2'd0, 5'd0, 5'd0, 5'd4, 32'h44, 32'h0, 32'h0);
    checkOutput("midreset_busy", {31'b0, wb_busy}, 32'h0);
    idle(5'd3, 5'd4);
    checkOutput("midreset_r3", read_data1, 32'h0);
    checkOutput("midreset_r4", read_data2, 32'h0);
    checkOutput("midreset_done", {31'b0, wb_done}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 2) != 0),
                    2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)),
                    $urandom, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
